// File: rtl/ula_op_sequencer_if.sv
// Request, datapath and response signals of the ULA op sequencer.
// Sequencer side is the slave (serves requests); master is the requester/datapath environment.
interface ula_op_sequencer_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [2:0]   sel;
    logic         mc_start;
    logic         mc_done;
    logic [W-1:0] mux_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic [1:0]   out_err;

    modport slave (
        input  in_valid, in_op, in_a, in_b, mc_done, mux_y, out_ready,
        output in_ready, opa, opb, sel, mc_start, out_valid, out_y, out_err
    );

    modport master (
        output in_valid, in_op, in_a, in_b, mc_done, mux_y, out_ready,
        input  in_ready, opa, opb, sel, mc_start, out_valid, out_y, out_err
    );
endinterface

// File: rtl/ula_op_sequencer.sv
// Purpose: drives operands/select of the ULA mux for one request at a time, start/done for DIV/MULT.
// Latency: 1 cycle (error shortcuts), 2 (logic/arith), mc_done+1 or TIMEOUT+2 (DIV/MULT).
// Backpressure: in_ready only in IDLE, no skid; response held in RESP until out_ready.
module ula_op_sequencer #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    ula_op_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, START, WAIT, RESP} state_t;

    localparam logic [2:0] OP_DIV    = 3'b000;
    localparam logic [2:0] OP_MULT   = 3'b110;
    localparam logic [2:0] OP_ILL    = 3'b111;
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_DIV0  = 2'b01;
    localparam logic [1:0] ERR_ILL   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t       state, state_nxt;
    logic [W-1:0] opa_q, opb_q, out_y_q;
    logic [2:0]   sel_q;
    logic [1:0]   out_err_q;
    logic [7:0]   cnt, cnt_inc;
    logic         in_ready_c, mc_start_c, out_valid_c;
    logic         accept, b_zero, timeout_hit;

    assign accept      = bus.in_valid && in_ready_c;
    assign b_zero      = (bus.in_b == '0);
    // Saturating wait counter; the post-increment value is what reaches TIMEOUT.
    assign cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_op == OP_ILL)       state_nxt = RESP;
                    else if (bus.in_op == OP_MULT) state_nxt = START;
                    else if (bus.in_op == OP_DIV)  state_nxt = b_zero ? RESP : START;
                    else                           state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            START:   state_nxt = WAIT;
            WAIT:    if (bus.mc_done || timeout_hit) state_nxt = RESP;
            RESP:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = (state == IDLE) && !rst;
        mc_start_c  = (state == START);
        out_valid_c = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q     <= '0;
            opb_q     <= '0;
            sel_q     <= '0;
            out_y_q   <= '0;
            out_err_q <= ERR_OK;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa_q <= bus.in_a;
                        opb_q <= bus.in_b;
                        sel_q <= bus.in_op;
                        if (bus.in_op == OP_ILL) begin
                            out_y_q   <= '0;
                            out_err_q <= ERR_ILL;
                        end else if (bus.in_op == OP_DIV && b_zero) begin
                            out_y_q   <= '0;
                            out_err_q <= ERR_DIV0;
                        end
                    end
                end
                EXEC: begin
                    out_y_q   <= bus.mux_y;
                    out_err_q <= ERR_OK;
                end
                START: cnt <= '0;
                WAIT: begin
                    cnt <= cnt_inc;
                    // mc_done beats a simultaneous timeout.
                    if (bus.mc_done) begin
                        out_y_q   <= bus.mux_y;
                        out_err_q <= ERR_OK;
                    end else if (timeout_hit) begin
                        out_y_q   <= '0;
                        out_err_q <= ERR_TMO;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mc_start  = mc_start_c;
    assign bus.out_valid = out_valid_c;
    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.sel       = sel_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_ula_op_sequencer.sv
// Bench for ula_op_sequencer: mux/multi-cycle unit models, scoreboard queue and a response monitor.
module tb_ula_op_sequencer;
    localparam int W  = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ula_op_sequencer_if #(.W(W)) bus ();
    ula_op_sequencer #(.W(W), .TIMEOUT(TO)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] op;
        logic [7:0] y;
        logic [1:0] err;
        int         lat;
        int         mcs;
        int         acc;
        int         base;
    } exp_t;

    exp_t exp_q[$];
    int   mc_total  = 0;
    int   mc_delay  = 0;
    int   bp_until  = 0;
    int   last_acc  = 0;
    bit   rnd_ready = 1'b0;
    bit   in_resp   = 1'b0;
    logic [7:0] mux_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Reference: result, error and latency straight from the opcode rules.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input int d);
        exp_t e;
        logic [7:0] r;
        bit mc;
        e.op = op; e.y = 8'h00; e.err = 2'd0; e.lat = 2; e.mcs = 0; e.acc = 0; e.base = 0;
        r = 8'h00; mc = 1'b0;
        case (op)
            3'd1: e.y = a & b;
            3'd2: e.y = a | b;
            3'd3: e.y = a ^ b;
            3'd4: e.y = a + b;
            3'd5: e.y = a - b;
            3'd6: begin mc = 1'b1; r = a * b; end
            3'd0: begin
                if (b == 8'h00) begin e.err = 2'd1; e.lat = 1; end
                else begin mc = 1'b1; r = a / b; end
            end
            default: begin e.err = 2'd2; e.lat = 1; end
        endcase
        if (mc) begin
            e.mcs = 1;
            if (d >= 1 && d <= TO) begin e.y = r; e.lat = d + 2; end
            else begin e.err = 2'd3; e.lat = TO + 2; end
        end
        return e;
    endfunction

    // Mux model: multi-cycle results only appear while mc_done is high.
    always_comb begin
        case (bus.sel)
            3'd1:    mux_v = bus.opa & bus.opb;
            3'd2:    mux_v = bus.opa | bus.opb;
            3'd3:    mux_v = bus.opa ^ bus.opb;
            3'd4:    mux_v = bus.opa + bus.opb;
            3'd5:    mux_v = bus.opa - bus.opb;
            3'd6:    mux_v = bus.mc_done ? 8'(bus.opa * bus.opb) : 8'hEE;
            3'd0:    mux_v = (bus.mc_done && bus.opb != 8'h00) ? bus.opa / bus.opb : 8'hEE;
            default: mux_v = 8'h5A;
        endcase
    end
    assign bus.mux_y = mux_v;

    initial begin
        int done_at;
        done_at = -1;
        bus.mc_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mc_start === 1'b1 && mc_delay > 0) done_at = cyc + mc_delay;
            bus.mc_done = (cyc == done_at);
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc < bp_until) bus.out_ready = 1'b0;
            else if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            else                bus.out_ready = 1'b1;
        end
    end

    initial begin
        exp_t e;
        logic [7:0] hy;
        logic [1:0] herr;
        hy = 8'h00; herr = 2'd0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                in_resp = 1'b0;
                continue;
            end
            if (bus.mc_start === 1'b1) mc_total++;
            if (bus.out_valid === 1'b1) begin
                check("valid_ready_excl", bus.in_ready, 1'b0);
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        check("resp_without_request", bus.out_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_y", bus.out_y, e.y);
                        check("out_err", bus.out_err, e.err);
                        check("latency", cyc - e.acc, e.lat);
                        check("mc_start_pulses", mc_total - e.base, e.mcs);
                        check("sel_in_resp", bus.sel, e.op);
                    end
                    hy = bus.out_y;
                    herr = bus.out_err;
                    in_resp = 1'b1;
                end else begin
                    check("out_y_stable", bus.out_y, hy);
                    check("out_err_stable", bus.out_err, herr);
                end
                if (bus.out_ready === 1'b1) in_resp = 1'b0;
            end
        end
    end

    task automatic req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int d, input bit want);
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        mc_delay = d;
        bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("accept_timeout", bus.in_ready, 1'b1);
            bus.in_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        if (want) begin
            e = model(op, a, b, d);
            e.acc = cyc;
            e.base = mc_total;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_op = 3'($urandom);
        bus.in_a = 8'($urandom);
        bus.in_b = 8'($urandom);
        check("sel_after_accept", bus.sel, op);
        check("opa_after_accept", bus.opa, a);
        check("opb_after_accept", bus.opb, b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_resp) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size() + int'(in_resp), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check({tag, "_opa"}, bus.opa, 8'h00);
        check({tag, "_opb"}, bus.opb, 8'h00);
        check({tag, "_sel"}, bus.sel, 3'b000);
        check({tag, "_mc_start"}, bus.mc_start, 1'b0);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_y"}, bus.out_y, 8'h00);
        check({tag, "_out_err"}, bus.out_err, 2'b00);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] op;
        logic [7:0] a, b;
        int d, bpu;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = 8'h00; bus.in_b = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", bus.in_ready, 1'b1);

        req(3'd4, 8'h7F, 8'h01, 0, 1'b1);
        req(3'd6, 8'h0C, 8'h0A, 3, 1'b1);
        req(3'd6, 8'h0C, 8'h0A, 5, 1'b1);   // done lands in RESP: timeout, late done ignored
        req(3'd0, 8'h33, 8'h00, 2, 1'b1);
        req(3'd7, 8'h12, 8'h34, 2, 1'b1);
        req(3'd0, 8'h10, 8'h02, 0, 1'b1);
        req(3'd0, 8'h10, 8'h02, TO, 1'b1);
        drain();

        bpu = cyc + 14;
        bp_until = bpu;
        req(3'd3, 8'hF0, 8'h3C, 0, 1'b1);
        req(3'd4, 8'h01, 8'h02, 0, 1'b1);
        check("accept_after_bp_handshake", last_acc, bpu + 1);
        drain();

        req(3'd6, 8'h0C, 8'h0A, 3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        req(3'd4, 8'h7F, 8'h01, 0, 1'b1);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            d  = $urandom_range(0, 6);
            req(op, a, b, d, 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
